spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  - Receive end of the 3-wire SPI link (SEN active low, SCLK, SDATA) driven by SPI_cntrl.
//  - Oversamples SEN/SCLK/SDATA with the system clock, deserialises DATA_W-bit words MSB first
//    and pushes them into an internal FIFO that the local logic drains.
//  - Sits at the peripheral/ASIC side of the board link, opposite the SPI_cntrl master.
// PARAMETERS
//  - DATA_W      24  bits per SPI word
//  - FIFO_DEPTH  8   receive FIFO entries; power of two, >= 2
//  - FIFO_AW     3   log2(FIFO_DEPTH)
// PORTS
//  - clock       in   1       system clock; all logic on rising edge
//  - reset       in   1       asynchronous, active-high reset
//  - SEN         in   1       serial enable from master, active low (async to clock)
//  - SCLK        in   1       serial clock from master (async to clock)
//  - SDATA       in   1       serial data, valid on SCLK rising edge
//  - fifo_rden   in   1       pop head word when data_empty = 0
//  - data_out    out  DATA_W  FIFO head word (first-word fall-through)
//  - data_full   out  1       FIFO holds FIFO_DEPTH words
//  - data_empty  out  1       FIFO holds no words
//  - busy        out  1       frame in progress (synchronised SEN low)
//  - overflow    out  1       sticky: word dropped because FIFO was full
//  - frame_err   out  1       sticky: SEN rose with a partial word
//  - clr_status  in   1       synchronous clear of overflow and frame_err
// BEHAVIOUR
//  - Reset: data_out=0, data_full=0, data_empty=1, busy=0, overflow=0, frame_err=0;
//    FIFO pointers, shift reg, bit counter cleared, FSM -> IDLE. Reset mid-frame discards the
//    partial word and all stored words; after release, FSM waits for SEN high before arming.
//  - Inputs pass 2-flop synchronisers; SCLK rise and SEN fall/rise detected on synced values.
//  - Requirement on master: SCLK high and low phases each >= 2 clock periods (clk_ratio >= 4).
//  - FSM IDLE: busy=0, bit_cnt=0. Synced SEN falling -> SHIFT.
//  - FSM SHIFT: busy=1. Each synced SCLK rise: shreg <= {shreg[DATA_W-2:0], SDATA_sync},
//    bit_cnt++. On the DATA_W-th rise: word pushed next cycle, bit_cnt <= 0, stay SHIFT
//    (back-to-back words within one SEN-low frame are legal; SPI_cntrl sends 3 per frame).
//  - SHIFT, synced SEN rising: -> IDLE. bit_cnt != 0 -> partial word discarded (see macro).
//  - SCLK edges while SEN high are ignored.
//  - Latency: data_empty deasserts 3-4 clock cycles after last-bit SCLK rise at the pin
//    (1 cycle synchroniser uncertainty); never more than 4.
//  - FIFO: registered pointers with extra wrap bit; full = ptr MSBs differ, low bits equal.
//    data_out = mem[rd_ptr] combinationally from registered storage; valid while !data_empty.
//  - fifo_rden with data_empty=1: ignored, pointers unchanged.
//  - Push with data_full=1 and no pop same cycle: word dropped, overflow <= 1.
//  - Push and pop same cycle: both occur, count unchanged (including when full or empty+push
//    is not possible: pop ignored when empty, push proceeds).
//  - Pointer wrap at FIFO_DEPTH is seamless; no loss across wrap.
//  - clr_status clears both sticky flags; a set event in the same cycle wins (flag stays 1).
// CONFIGURATION
//  - SPI_RX_FRAME_ERR_EN defined: SEN rise with bit_cnt != 0 sets frame_err; partial dropped.
//  - SPI_RX_FRAME_ERR_EN undefined: frame_err tied 0; partial word silently dropped.
//    FIFO contents and all other behaviour identical in both builds.
// TESTING
//  - Reset: reset=1 mid-run -> data_empty=1, busy=0, overflow=0, frame_err=0, data_out=0.
//  - Drive SPI_cntrl (clk_ratio=8) with 0x0019ac, 0xffa5a5, 0xf0abcd in one frame ->
//    three pops return exactly those words in order, then data_empty=1, no flags set.
//  - Send 9 words, FIFO_DEPTH=8, no reads -> data_full=1, overflow=1, pops return words 1..8;
//    clr_status -> overflow=0.
//  - Frame with 10 bits then SEN high -> nothing pushed; frame_err=1 with SPI_RX_FRAME_ERR_EN,
//    0 without; next full word 0x123456 received correctly.
//  - Pop every word as it lands over 20 words (pointer wrap twice) -> order preserved,
//    data_full never 1; fifo_rden while empty -> no pointer change.
//  - SCLK toggled 24 times with SEN high -> busy=0, data_empty stays 1.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   Receive end of a 3-wire SPI link (SEN active low, SCLK, SDATA). The serial
//   inputs are oversampled with the system clock. DATA_W-bit words are
//   deserialised MSB first and pushed into a first-word-fall-through FIFO,
//   which the local logic drains.
//
//   Optional feature macro: SPI_RX_FRAME_ERR_EN
//     defined   : SEN rising with a partial word sets the sticky frame_err flag.
//     undefined : frame_err is tied to 0. The partial word is dropped silently.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   SEN         serial enable, active low (asynchronous to clock)
//   SCLK        serial clock (asynchronous to clock)
//   SDATA       serial data, sampled on the SCLK rising edge
//   fifo_rden   pop the head word; ignored while data_empty=1
//   data_out    FIFO head word; 0 while the FIFO is empty
//   data_full   FIFO holds FIFO_DEPTH words
//   data_empty  FIFO holds no words
//   busy        frame in progress
//   overflow    sticky: a word was dropped because the FIFO was full
//   frame_err   sticky: SEN rose in the middle of a word
//   clr_status  synchronous clear of overflow and frame_err
module spi_slave_rx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              SEN,
  input  logic              SCLK,
  input  logic              SDATA,
  input  logic              fifo_rden,
  output logic [DATA_W-1:0] data_out,
  output logic              data_full,
  output logic              data_empty,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_status
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Stage p0/p1: two-flop synchronisers. Stage p2: previous value, used for edge detection.
  // The SEN flops reset to 0. As a result, a SEN held low across reset
  // release never looks like a falling edge, and the receiver arms only
  // after it has seen SEN high.
  logic sen_p0, sen_p1, sen_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic sdata_p0, sdata_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sen_p0  <= 1'b0;
      sen_p1  <= 1'b0;
      sen_p2  <= 1'b0;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
    end else begin
      sen_p0  <= SEN;
      sen_p1  <= sen_p0;
      sen_p2  <= sen_p1;
      sclk_p0 <= SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
    end
  end

  // sdata_p1 has the same latency as sclk_p1, so it is sampled aligned with the detected rise.
  always_ff @(posedge clock) begin
    sdata_p0 <= SDATA;
    sdata_p1 <= sdata_p0;
  end

  logic sclk_rise, sen_fall, sen_rise;
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sen_fall  = sen_p2 & ~sen_p1;
  assign sen_rise  = sen_p1 & ~sen_p2;

  // Stage p3: deserialiser FSM. vld_p3 flags a complete word in shreg for one cycle.
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              vld_p3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      vld_p3  <= 1'b0;
    end else begin
      vld_p3 <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (sen_fall) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sen_rise) begin
            // Any partial word is abandoned. The bits left in shreg are
            // never pushed, because vld_p3 is only raised on a full count.
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shreg <= {shreg[DATA_W-2:0], sdata_p1};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              vld_p3  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage p4: FIFO write. shreg holds steady for at least two cycles after
  // the last rise, so it can serve directly as the write data.
  logic [FIFO_AW:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              do_pop, do_push;

  assign data_empty = (wr_ptr == rd_ptr);
  assign data_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_pop     = fifo_rden & ~data_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign do_push    = vld_p3 & (~data_full | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
  end

  // Gating on data_empty keeps data_out at 0 after reset, because mem itself is not cleared.
  assign data_out = data_empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

  // A set event wins over clr_status in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              overflow <= 1'b0;
    else if (vld_p3 & data_full & ~do_pop)  overflow <= 1'b1;
    else if (clr_status)                    overflow <= 1'b0;
  end

`ifdef SPI_RX_FRAME_ERR_EN
  logic frame_set;
  assign frame_set = (state == SHIFT) & sen_rise & (bit_cnt != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           frame_err <= 1'b0;
    else if (frame_set)  frame_err <= 1'b1;
    else if (clr_status) frame_err <= 1'b0;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx. The SPI master runs at clk_ratio 8, so each
// SCLK phase lasts 4 clock periods. Expected words are pushed to a
// scoreboard queue as they are sent and are compared when they are popped.
module tb_spi_slave_rx;

  localparam int HALF = 40;  // SCLK half period in ns (4 clocks of 10 ns)
`ifdef SPI_RX_FRAME_ERR_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        SEN, SCLK, SDATA;
  logic        fifo_rden, clr_status;
  logic [23:0] data_out;
  logic        data_full, data_empty, busy, overflow, frame_err;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        full_seen = 1'b0;

  spi_slave_rx dut (
    .clock(clock), .reset(reset), .SEN(SEN), .SCLK(SCLK), .SDATA(SDATA),
    .fifo_rden(fifo_rden), .data_out(data_out), .data_full(data_full),
    .data_empty(data_empty), .busy(busy), .overflow(overflow),
    .frame_err(frame_err), .clr_status(clr_status)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mon_en && data_full) full_seen = 1'b1;

  initial begin
    #3ms;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic spi_bit(input logic b);
    SDATA = b;
    #HALF SCLK = 1'b1;
    #HALF SCLK = 1'b0;
  endtask

  task automatic spi_word(input logic [23:0] w, input bit expect_store);
    for (int i = 23; i >= 0; i--) spi_bit(w[i]);
    if (expect_store) exp_q.push_back(w);
  endtask

  task automatic frame_begin();
    SEN = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF SEN = 1'b1;
    #(2*HALF);
  endtask

  task automatic pop_word(output logic [23:0] got, output logic was_empty);
    @(negedge clock);
    got = data_out;
    was_empty = data_empty;
    fifo_rden = 1'b1;
    @(negedge clock);
    fifo_rden = 1'b0;
  endtask

  task automatic wait_nonempty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!data_empty) begin ok = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [23:0] w;
    logic        e;
    // Values at power-up, right after reset release
    checks++;
    if ({data_empty, data_full, busy, overflow, frame_err} !== 5'b10000 || data_out !== 24'h0) begin
      failures++;
      $display("FAIL reset_init flags(empty,full,busy,ovf,ferr)=%b data_out=%h required 10000/000000",
               {data_empty, data_full, busy, overflow, frame_err}, data_out);
    end
    // Store one word, then assert reset in the middle of the next word
    frame_begin();
    spi_word(24'habcdef, 1'b0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    checks++;
    if (busy !== 1'b1 || data_empty !== 1'b0) begin
      failures++;
      $display("FAIL reset_prefill busy=%b empty=%b required 1/0", busy, data_empty);
    end
    #3 reset = 1'b1;
    #20;
    checks++;
    if ({data_empty, data_full, busy, overflow, frame_err} !== 5'b10000 || data_out !== 24'h0) begin
      failures++;
      $display("FAIL reset_midrun flags=%b data_out=%h required 10000/000000",
               {data_empty, data_full, busy, overflow, frame_err}, data_out);
    end
    @(negedge clock);
    reset = 1'b0;
    // SEN is still low after release, so the receiver must stay idle
    spi_bit(1'b1);
    spi_bit(1'b0);
    checks++;
    if (busy !== 1'b0 || data_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait_sen busy=%b empty=%b required 0/1", busy, data_empty);
    end
    frame_end();
    checks++;
    if (frame_err !== 1'b0 || data_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_after_sen frame_err=%b empty=%b required 0/1", frame_err, data_empty);
    end
    exp_q.delete();
    // A normal word after reset still gets through
    frame_begin();
    spi_word(24'h654321, 1'b1);
    frame_end();
    w = exp_q.pop_front();
    pop_word(w, e);
    checks++;
    if (e !== 1'b0 || w !== 24'h654321) begin
      failures++;
      $display("FAIL reset_recover got=%h empty=%b required 654321/0", w, e);
    end
  endtask

  task automatic test_three_words();
    logic [23:0] got, exp;
    logic        e;
    frame_begin();
    spi_word(24'h0019ac, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL three_busy busy=%b required 1", busy);
    end
    spi_word(24'hffa5a5, 1'b1);
    spi_word(24'hf0abcd, 1'b1);
    frame_end();
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      pop_word(got, e);
      checks++;
      if (e !== 1'b0 || got !== exp) begin
        failures++;
        $display("FAIL three_word%0d got=%h empty=%b required %h/0", i, got, e, exp);
      end
    end
    @(negedge clock);
    checks++;
    if ({data_empty, overflow, frame_err, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL three_final empty,ovf,ferr,busy=%b required 1000",
               {data_empty, overflow, frame_err, busy});
    end
  endtask

  task automatic test_latency();
    logic [23:0] w, got, exp;
    logic        e;
    int          cnt;
    w = 24'h5a5a5b;
    frame_begin();
    for (int i = 23; i >= 1; i--) spi_bit(w[i]);
    SDATA = w[0];
    #HALF SCLK = 1'b1;
    exp_q.push_back(w);
    cnt = 0;
    while (data_empty && cnt < 10) begin
      @(posedge clock);
      cnt++;
      #1;
    end
    checks++;
    if (cnt < 3 || cnt > 4) begin
      failures++;
      $display("FAIL latency cycles=%0d required 3..4", cnt);
    end
    @(negedge clock);
    #20 SCLK = 1'b0;
    frame_end();
    exp = exp_q.pop_front();
    pop_word(got, e);
    checks++;
    if (e !== 1'b0 || got !== exp) begin
      failures++;
      $display("FAIL latency_word got=%h required %h", got, exp);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] got, exp;
    logic        e;
    frame_begin();
    for (int i = 0; i < 9; i++) spi_word(24'h0a0000 + 24'(i) * 24'h010203, i < 8);
    frame_end();
    checks++;
    if (data_full !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flags full=%b overflow=%b required 1/1", data_full, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      pop_word(got, e);
      checks++;
      if (e !== 1'b0 || got !== exp) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%h empty=%b required %h/0", i, got, e, exp);
      end
    end
    @(negedge clock);
    checks++;
    if (data_empty !== 1'b1 || data_full !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained empty=%b full=%b required 1/0", data_empty, data_full);
    end
    clr_status = 1'b1;
    @(negedge clock);
    clr_status = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear overflow=%b required 0", overflow);
    end
  endtask

  task automatic test_frame_err();
    logic [23:0] got, exp;
    logic        e;
    frame_begin();
    for (int i = 0; i < 10; i++) spi_bit(i[0]);
    frame_end();
    checks++;
    if (data_empty !== 1'b1 || busy !== 1'b0 || frame_err !== FE_EXP) begin
      failures++;
      $display("FAIL frame_partial empty=%b busy=%b frame_err=%b required 1/0/%b",
               data_empty, busy, frame_err, FE_EXP);
    end
    clr_status = 1'b1;
    @(negedge clock);
    clr_status = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_clear frame_err=%b required 0", frame_err);
    end
    frame_begin();
    spi_word(24'h123456, 1'b1);
    frame_end();
    exp = exp_q.pop_front();
    pop_word(got, e);
    checks++;
    if (e !== 1'b0 || got !== exp || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_next got=%h empty=%b ferr=%b required %h/0/0", got, e, frame_err, exp);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] got, exp;
    logic        e;
    bit          ok;
    full_seen = 1'b0;
    mon_en = 1'b1;
    frame_begin();
    for (int i = 0; i < 20; i++) begin
      spi_word(24'($urandom), 1'b1);
      wait_nonempty(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL wrap_arrive%0d word did not land within 40 cycles", i);
      end
      exp = exp_q.pop_front();
      pop_word(got, e);
      checks++;
      if (e !== 1'b0 || got !== exp) begin
        failures++;
        $display("FAIL wrap_word%0d got=%h empty=%b required %h/0", i, got, e, exp);
      end
    end
    frame_end();
    mon_en = 1'b0;
    checks++;
    if (full_seen !== 1'b0) begin
      failures++;
      $display("FAIL wrap_full data_full seen=%b required 0", full_seen);
    end
    // Pop while empty must not move the pointers
    @(negedge clock);
    fifo_rden = 1'b1;
    @(negedge clock);
    fifo_rden = 1'b0;
    @(negedge clock);
    checks++;
    if (data_empty !== 1'b1 || data_full !== 1'b0) begin
      failures++;
      $display("FAIL empty_pop empty=%b full=%b required 1/0", data_empty, data_full);
    end
    frame_begin();
    spi_word(24'h7e57ab, 1'b1);
    frame_end();
    exp = exp_q.pop_front();
    pop_word(got, e);
    @(negedge clock);
    checks++;
    if (e !== 1'b0 || got !== exp || data_empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_pop_next got=%h was_empty=%b now_empty=%b required %h/0/1",
               got, e, data_empty, exp);
    end
  endtask

  task automatic test_sclk_sen_high();
    logic busy_seen;
    busy_seen = 1'b0;
    SEN = 1'b1;
    for (int i = 0; i < 24; i++) begin
      spi_bit(1'($urandom));
      if (busy) busy_seen = 1'b1;
    end
    #(2*HALF);
    checks++;
    if (busy_seen !== 1'b0 || busy !== 1'b0 || data_empty !== 1'b1) begin
      failures++;
      $display("FAIL sen_high busy_seen=%b busy=%b empty=%b required 0/0/1",
               busy_seen, busy, data_empty);
    end
  endtask

  initial begin
    reset = 1'b1;
    SEN = 1'b1;
    SCLK = 1'b0;
    SDATA = 1'b0;
    fifo_rden = 1'b0;
    clr_status = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    test_reset();
    test_three_words();
    test_latency();
    test_overflow();
    test_frame_err();
    test_wrap();
    test_sclk_sen_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
